clock_hms_settable: RTL and testbench
=====================================

// Module: clock_hms_settable
// PURPOSE
//   Parametrised HH:MM:SS time-of-day clock driving six 7-segment digits; successor to the fixed 50 MHz clock.
//   Adds a configurable input frequency, time-set mode (set hour/minute with two buttons) and a blinking field under edit.
//   Also adds a 12/24 h display with PM flag and selectable segment polarity.
//   Time is held directly as BCD digits (no divide/modulo), registered outputs; sits between board buttons and the display pins.
// PARAMETERS
//   CLK_HZ          50_000_000  input clock frequency; one second = CLK_HZ cycles (sim uses 10)
//   SEG_ACTIVE_LOW  1           1: segment on = 0; 0: segment on = 1
//   BLANK_HR_LZ     1           1: blank hour tens digit when 0 in 12 h mode
// PORTS
//   clk        in   1  single clock, all logic on posedge
//   reset      in   1  asynchronous, active-high; clears everything
//   switch     in   1  display mode: 0 = 24 h, 1 = 12 h (display only, timekeeping always 24 h)
//   btn_set    in   1  single-cycle pulse, already debounced/synchronised; advances set FSM
//   btn_inc    in   1  single-cycle pulse, already debounced/synchronised; increments field under edit
//   led_a      out  7  seconds units segments, bit6=a .. bit0=g
//   led_b      out  7  seconds tens
//   led_c      out  7  minutes units
//   led_d      out  7  minutes tens
//   led_e      out  7  hours units
//   led_f      out  7  hours tens
//   pm         out  1  1 when 24 h hour is 12..23 (valid in both modes)
//   setting    out  1  1 while FSM not in RUN
//   tick_1hz   out  1  one-cycle pulse at each second boundary
// BEHAVIOUR
//   Reset: time 00:00:00, prescaler 0, FSM RUN, pm=0, setting=0, tick_1hz=0.
//   Reset: led_a..led_f show "0" (7'b0000001 if active-low; in 12 h mode hour shows "12", tens blanked only if BLANK_HR_LZ).
//   Prescaler: counts 0..CLK_HZ-1, width $clog2(CLK_HZ); at CLK_HZ-1 wraps to 0 and tick_1hz=1 next cycle.
//   RUN: on tick, seconds+1; 59->00 carries minutes; 59->00 carries hours; 23:59:59 -> 00:00:00 in the same tick.
//   FSM: RUN -btn_set-> SET_HH -btn_set-> SET_MM -btn_set-> RUN.
//   FSM: on SET_MM->RUN, seconds := 00 and prescaler := 0 (start of a fresh second).
//   SET_HH / SET_MM: time does not advance (tick_1hz still pulses); btn_inc adds 1 to selected field only.
//   Field wrap in set mode: hours 23->00, minutes 59->00; never carries into another field.
//   btn_set and btn_inc in same cycle: btn_set wins, btn_inc dropped.
//   Blink: in SET_HH/SET_MM the two digits of the edited field are blanked (all segments off) while prescaler >= CLK_HZ/2.
//   12 h map (switch=1): hour 0 -> 12; 1..12 -> same; 13..23 -> 1..11. switch change takes effect on next display update.
//   Latency: segment outputs registered; a digit change appears on led_* exactly 1 cycle after the state change.
//   Segment outputs are glitch-free.
//   Reset mid-operation (incl. mid-set): immediate async return to reset values, FSM RUN.
// STRUCTURE
//   clock_pkg: SEG_0..SEG_9, SEG_BLANK (active-low canonical form, bit6=a); FSM state typedef {RUN, SET_HH, SET_MM}.
//   clock_pkg: function to_12h(bcd hour) -> bcd hour.
//   Sub-module seg7_decoder (4-bit BCD + blank + polarity -> 7 bits, combinational), instantiated 6x.
//   Top holds prescaler, BCD counters, FSM and output registers.
// TESTING (CLK_HZ=10 unless stated)
//   Reset, switch=0, hold 9 cycles -> all led_* = 7'b0000001, tick_1hz low; 10th cycle -> tick_1hz pulse, led_a = "1" one cycle later.
//   Preload via set to 23:59, run 60 ticks -> 23:59:59 then 00:00:00 in one tick, pm 1->0.
//   btn_set, 5x btn_inc, btn_set, 3x btn_inc, btn_set -> time 05:03:00, prescaler 0, setting 0, counts resume.
//   In SET_HH -> led_e/led_f blank exactly on prescaler 5..9 each second, minutes never blank.
//   Same-cycle btn_set+btn_inc -> FSM advances, field unchanged.
//   switch=1 at 00:xx -> hours "12", pm=0; at 13:xx -> led_e "1", led_f blank, pm=1.
//   Assert reset while in SET_MM -> next cycle 00:00:00, setting=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the HH:MM:SS clock: canonical active-low
// segment codes (bit6=a .. bit0=g), set-mode FSM states and BCD helpers.
package clock_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2
    } state_t;

    // Two-digit BCD increment that wraps to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    // 24 h BCD hour -> 12 h BCD hour (00 -> 12, 13..23 -> 01..11).
    function automatic logic [7:0] to_12h(input logic [7:0] hour);
        if (hour == 8'h00)
            return 8'h12;
        if (hour <= 8'h12)
            return hour;
        if (hour[7:4] == 4'd1)
            return {4'd0, hour[3:0] - 4'd2};
        if (hour[3:0] < 4'd2)
            return {4'd0, hour[3:0] + 4'd8};
        return {4'd1, hour[3:0] - 4'd2};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to 7-segment pattern with blanking and selectable polarity.
module seg7_decoder
    import clock_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] code;

    always_comb begin
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        if (blank)
            code = SEG_BLANK;
        seg = ACTIVE_LOW ? code : ~code;
    end

endmodule

// File: rtl/clock_hms_settable.sv
// Settable HH:MM:SS clock with BCD time registers, 12/24 h display, blinking
// edit field and registered 7-segment outputs.
module clock_hms_settable
    import clock_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_HR_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic [6:0] led_a,
    output logic [6:0] led_b,
    output logic [6:0] led_c,
    output logic [6:0] led_d,
    output logic [6:0] led_e,
    output logic [6:0] led_f,
    output logic       pm,
    output logic       setting,
    output logic       tick_1hz
);

    localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [6:0]      SEG_RST    = SEG_ACTIVE_LOW ? SEG_0 : ~SEG_0;

    state_t                         state;
    logic [PW-1:0]                  presc;
    logic [7:0]                     hour, minute, sec;
    logic                           wrap;
    logic [7:0]                     hr_disp;
    logic [NUM_DIGITS-1:0][3:0]     dig;
    logic [NUM_DIGITS-1:0]          blk;
    logic [NUM_DIGITS-1:0][6:0]     seg, seg_q;

    assign wrap = (presc == PRESC_MAX);

    // Leaving SET_MM restarts the second so the new time begins on a boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= wrap;
            if (wrap || (state == SET_MM && btn_set))
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            setting <= 1'b0;
            hour    <= 8'h00;
            minute  <= 8'h00;
            sec     <= 8'h00;
        end else begin
            if (btn_set) begin
                case (state)
                    RUN: begin
                        state   <= SET_HH;
                        setting <= 1'b1;
                    end
                    SET_HH: state <= SET_MM;
                    default: begin
                        state   <= RUN;
                        setting <= 1'b0;
                        sec     <= 8'h00;
                    end
                endcase
            end else if (btn_inc) begin
                if (state == SET_HH)
                    hour <= bcd_inc(hour, 8'h23);
                else if (state == SET_MM)
                    minute <= bcd_inc(minute, 8'h59);
            end

            if (state == RUN && wrap) begin
                sec <= bcd_inc(sec, 8'h59);
                if (sec == 8'h59) begin
                    minute <= bcd_inc(minute, 8'h59);
                    if (minute == 8'h59)
                        hour <= bcd_inc(hour, 8'h23);
                end
            end
        end
    end

    always_comb begin
        hr_disp = switch ? to_12h(hour) : hour;
        dig     = {hr_disp[7:4], hr_disp[3:0], minute[7:4], minute[3:0], sec[7:4], sec[3:0]};
        blk     = '0;
        if (presc >= PRESC_HALF && state == SET_HH)
            blk[5:4] = 2'b11;
        if (presc >= PRESC_HALF && state == SET_MM)
            blk[3:2] = 2'b11;
        if (switch && BLANK_HR_LZ && hr_disp[7:4] == 4'd0)
            blk[5] = 1'b1;
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .bcd   (dig[i]),
            .blank (blk[i]),
            .seg   (seg[i])
        );
    end

    // Registered so the pins never see decoder hazards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= {NUM_DIGITS{SEG_RST}};
            pm    <= 1'b0;
        end else begin
            seg_q <= seg;
            pm    <= (hour >= 8'h12);
        end
    end

    assign led_a = seg_q[0];
    assign led_b = seg_q[1];
    assign led_c = seg_q[2];
    assign led_d = seg_q[3];
    assign led_e = seg_q[4];
    assign led_f = seg_q[5];

endmodule

// File: tb/tb_clock_hms_settable.sv
// Scoreboard bench for clock_hms_settable: a time-of-day model in plain
// integers predicts each cycle's outputs; a monitor compares them.
module tb_clock_hms_settable;

    localparam int HZ = 10;
    localparam logic [6:0] SEG_TAB [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0, reset = 1'b0, switch = 1'b0, btn_set = 1'b0, btn_inc = 1'b0;
    logic [6:0] led_a, led_b, led_c, led_d, led_e, led_f;
    logic       pm, setting, tick_1hz;

    clock_hms_settable #(.CLK_HZ(HZ), .SEG_ACTIVE_LOW(1'b1), .BLANK_HR_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .switch(switch), .btn_set(btn_set), .btn_inc(btn_inc),
        .led_a(led_a), .led_b(led_b), .led_c(led_c), .led_d(led_d), .led_e(led_e), .led_f(led_f),
        .pm(pm), .setting(setting), .tick_1hz(tick_1hz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][6:0] led;
        logic            tick;
        logic            pm;
        logic            setting;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;
    int   hh = 0, mm = 0, ss = 0, pre = 0, mode = 0;
    bit   sw_cur = 1'b0;

    function automatic logic [6:0] seg_of(input int d, input bit blank);
        return blank ? BLANK : SEG_TAB[d];
    endfunction

    task automatic check(input string nm, input logic [41:0] got, input logic [41:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
        end
    endtask

    // One clock: drive inputs, predict what the pins show after this edge, step the model.
    task automatic cycle(input bit bs, input bit bi);
        exp_t e;
        int   dh;
        bit   hb, mb, wrap;
        @(negedge clk);
        reset = 1'b0; switch = sw_cur; btn_set = bs; btn_inc = bi;
        dh = switch ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
        hb = (mode == 1) && (pre >= HZ / 2);
        mb = (mode == 2) && (pre >= HZ / 2);
        e.led[0] = seg_of(ss % 10, 1'b0);
        e.led[1] = seg_of(ss / 10, 1'b0);
        e.led[2] = seg_of(mm % 10, mb);
        e.led[3] = seg_of(mm / 10, mb);
        e.led[4] = seg_of(dh % 10, hb);
        e.led[5] = seg_of(dh / 10, hb || (switch && dh < 10));
        e.pm     = (hh >= 12);
        wrap     = (pre == HZ - 1);
        e.tick   = wrap;
        pre      = wrap ? 0 : pre + 1;
        if (mode == 0 && wrap) begin
            ss++;
            if (ss == 60) begin ss = 0; mm++; end
            if (mm == 60) begin mm = 0; hh++; end
            if (hh == 24) hh = 0;
        end
        if (bs) begin
            if (mode == 2) begin ss = 0; pre = 0; end
            mode = (mode + 1) % 3;
        end else if (bi) begin
            if (mode == 1) hh = (hh + 1) % 24;
            else if (mode == 2) mm = (mm + 1) % 60;
        end
        e.setting = (mode != 0);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1; btn_set = 1'b0; btn_inc = 1'b0; sw_cur = 1'b0; switch = 1'b0;
        hh = 0; mm = 0; ss = 0; pre = 0; mode = 0;
        e.led = {6{SEG_TAB[0]}};
        e.tick = 1'b0; e.pm = 1'b0; e.setting = 1'b0;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led", 42'({led_f, led_e, led_d, led_c, led_b, led_a}), 42'(e.led));
            check("tick_1hz", 42'(tick_1hz), 42'(e.tick));
            check("pm", 42'(pm), 42'(e.pm));
            check("setting", 42'(setting), 42'(e.setting));
        end
    end

    initial begin
        int r;
        do_reset();
        do_reset();
        repeat (25) cycle(1'b0, 1'b0);
        // 05:03:00 via the set sequence
        cycle(1'b1, 1'b0); repeat (5) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0); repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (23) cycle(1'b0, 1'b0);
        // 23:59, then across midnight
        cycle(1'b1, 1'b0); repeat (18) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0); repeat (56) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (605) cycle(1'b0, 1'b0);
        sw_cur = 1'b1;
        repeat (15) cycle(1'b0, 1'b0);
        // 13:xx in 12 h mode
        cycle(1'b1, 1'b0); repeat (13) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b0);
        // set+inc in the same cycle, then reset while in SET_MM
        cycle(1'b1, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1); cycle(1'b0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0);
        do_reset();
        repeat (5) cycle(1'b0, 1'b0);
        repeat (4000) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 12) sw_cur = ~sw_cur;
                cycle(r >= 12 && r < 40, $urandom_range(0, 9) == 0);
            end
        end
        @(posedge clk);
        #2;
        check("scoreboard_drained", 42'(exp_q.size()), 42'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
